// File: rtl/xlink_rx_token_fifo.sv
// Purpose: receive-side XLink token buffer; circular FIFO of 9-bit tokens (bit 8 = control)
//          plus a credit tracker that asks the transmitter for CREDIT_UNIT tokens at a time.
// Latency: write visible on rx_buf_empty/fill_level after the write edge; read data is
//          registered and valid from the edge on which rx_buf_en is accepted.
// Backpressure: none toward the link; the far end is held off by credit. A token that
//          finds the FIFO full (and no same-cycle read) is dropped and flagged.
// Ports:
//   clk, reset                        - single clock, synchronous active-high reset
//   rx_token_in/rx_token_valid        - token write strobe from the link decoder
//   link_up                           - enables credit issue; low clears credit state
//   rx_buf_en/rx_buf_dout/rx_buf_empty - consumer read port (registered data)
//   credit_req/credit_ack             - credit issue handshake with the transmitter
//   fill_level, overflow, credit_err  - status (flags are sticky until reset)
module xlink_rx_token_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int CREDIT_UNIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8:0]            rx_token_in,
    input  logic                  rx_token_valid,
    input  logic                  link_up,
    input  logic                  rx_buf_en,
    output logic [8:0]            rx_buf_dout,
    output logic                  rx_buf_empty,
    output logic                  credit_req,
    input  logic                  credit_ack,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow,
    output logic                  credit_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int HW    = CW + 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } credit_state_t;

    logic [8:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         outstanding_next;
    credit_state_t         state;
    credit_state_t         state_next;

    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ack_acc;
    logic                  headroom_ok;
    logic [HW-1:0]         committed;

    // A full FIFO still takes a token when a read frees a slot on the same edge.
    assign rd_acc  = rx_buf_en && (count != '0);
    assign wr_acc  = rx_token_valid && ((count < CW'(DEPTH)) || rd_acc);
    assign ack_acc = (state == REQ) && credit_ack && link_up;

    // Headroom test written as count + outstanding + unit <= depth so it cannot underflow.
    assign committed   = HW'(count) + HW'(outstanding) + HW'(CREDIT_UNIT);
    assign headroom_ok = (committed <= HW'(DEPTH));

    assign fill_level = count;

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CW'(1);
        end
    end

    // An ack arriving with a token nets CREDIT_UNIT-1 even when outstanding is 0.
    always_comb begin
        outstanding_next = outstanding;
        if (!link_up) begin
            outstanding_next = '0;
        end else if (ack_acc) begin
            outstanding_next = outstanding + CW'(CREDIT_UNIT)
                             - (rx_token_valid ? CW'(1) : CW'(0));
        end else if (rx_token_valid && (outstanding != '0)) begin
            outstanding_next = outstanding - CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        credit_req = 1'b0;
        case (state)
            IDLE: begin
                if (link_up && headroom_ok) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                credit_req = 1'b1;
                if (credit_ack) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // One quiet cycle so headroom is re-evaluated with the new credit.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!link_up) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            outstanding  <= '0;
            state        <= IDLE;
            rx_buf_dout  <= '0;
            rx_buf_empty <= 1'b1;
            overflow     <= 1'b0;
            credit_err   <= 1'b0;
        end else begin
            count        <= count_next;
            outstanding  <= outstanding_next;
            state        <= state_next;
            rx_buf_empty <= (count_next == '0);
            if (wr_acc) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (rd_acc) begin
                rx_buf_dout <= mem[rd_ptr];
                rd_ptr      <= rd_ptr + DEPTH_LOG2'(1);
            end
            if (rx_token_valid && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rx_token_valid && (outstanding == '0)) begin
                credit_err <= 1'b1;
            end
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            mem[wr_ptr] <= rx_token_in;
        end
    end

endmodule

// File: tb/tb_xlink_rx_token_fifo.sv
module tb_xlink_rx_token_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] rx_token_in;
    logic       rx_token_valid;
    logic       link_up;
    logic       rx_buf_en;
    logic [8:0] rx_buf_dout;
    logic       rx_buf_empty;
    logic       credit_req;
    logic       credit_ack;
    logic [4:0] fill_level;
    logic       overflow;
    logic       credit_err;

    always #5 clk = ~clk;

    xlink_rx_token_fifo #(
        .DEPTH_LOG2 (4),
        .CREDIT_UNIT(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_token_in   (rx_token_in),
        .rx_token_valid(rx_token_valid),
        .link_up       (link_up),
        .rx_buf_en     (rx_buf_en),
        .rx_buf_dout   (rx_buf_dout),
        .rx_buf_empty  (rx_buf_empty),
        .credit_req    (credit_req),
        .credit_ack    (credit_ack),
        .fill_level    (fill_level),
        .overflow      (overflow),
        .credit_err    (credit_err)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] sb_q[$];
    int         m_count  = 0;
    logic       m_ovf    = 1'b0;
    int         peak     = 0;
    int         n_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of FIFO traffic; the model decides acceptance before the edge.
    task automatic cyc(input logic v, input logic [8:0] tok, input logic en);
        bit         rd;
        bit         wr;
        logic [8:0] exp_tok;
        rx_token_valid = v;
        rx_token_in    = tok;
        rx_buf_en      = en;
        rd = en && (m_count > 0);
        wr = v && ((m_count < 16) || rd);
        if (v && !wr) m_ovf = 1'b1;
        if (wr) sb_q.push_back(tok);
        tick();
        rx_token_valid = 1'b0;
        rx_buf_en      = 1'b0;
        if (rd) begin
            exp_tok = sb_q.pop_front();
            check("dout", 32'(rx_buf_dout), 32'(exp_tok));
        end
        m_count = m_count + (wr ? 1 : 0) - (rd ? 1 : 0);
        check("fill_level", 32'(fill_level), 32'(m_count));
        check("empty", 32'(rx_buf_empty), (m_count == 0) ? 32'd1 : 32'd0);
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (int'(fill_level) > peak) peak = int'(fill_level);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dout"}, 32'(rx_buf_dout), 32'd0);
        check({tag, "_empty"}, 32'(rx_buf_empty), 32'd1);
        check({tag, "_req"}, 32'(credit_req), 32'd0);
        check({tag, "_fill"}, 32'(fill_level), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_cerr"}, 32'(credit_err), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        peak    = 0;
    endtask

    // Serve credit requests for a bounded window, acking 2 cycles after each is seen.
    task automatic serve(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (credit_req) begin
                n++;
                tick();
                tick();
                credit_ack = 1'b1;
                tick();
                credit_ack = 1'b0;
                check("req_fall_on_ack", 32'(credit_req), 32'd0);
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        rx_token_in    = '0;
        rx_token_valid = 1'b0;
        link_up        = 1'b0;
        rx_buf_en      = 1'b0;
        credit_ack     = 1'b0;
        tick();
        tick();
        do_reset();
        check_reset_vals("rst");

        // Credit bring-up
        link_up = 1'b1;
        serve(40, n_req);
        check("bringup_nreq", 32'(n_req), 32'd2);
        check("bringup_outstanding", 32'(dut.outstanding), 32'd16);
        check("bringup_req_idle", 32'(credit_req), 32'd0);

        // Ordered stream with an EOM control token
        for (int i = 1; i <= 5; i++) cyc(1'b1, 9'(i), 1'b0);
        cyc(1'b1, 9'h101, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 9'h0, 1'b1);
            cyc(1'b0, 9'h0, 1'b0);
        end
        check("stream_peak", 32'(peak), 32'd6);
        check("stream_empty", 32'(rx_buf_empty), 32'd1);
        check("stream_cerr", 32'(credit_err), 32'd0);

        // Reads while empty are ignored
        for (int i = 0; i < 3; i++) cyc(1'b0, 9'h0, 1'b1);
        check("emptyrd_dout", 32'(rx_buf_dout), 32'h101);
        check("emptyrd_fill", 32'(fill_level), 32'd0);
        check("emptyrd_ovf", 32'(overflow), 32'd0);

        // Credit accounting, then credit exhaustion, overflow and wrap
        do_reset();
        link_up = 1'b1;
        serve(40, n_req);
        check("acct_bringup_nreq", 32'(n_req), 32'd2);
        for (int i = 0; i < 8; i++) cyc(1'b1, 9'(9'h20 + i), 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 9'h0, 1'b1);
        serve(30, n_req);
        check("acct_nreq", 32'(n_req), 32'd1);
        check("acct_outstanding", 32'(dut.outstanding), 32'd16);
        for (int i = 0; i < 16; i++) cyc(1'b1, 9'(9'h40 + i), 1'b0);
        check("full_fill", 32'(fill_level), 32'd16);
        check("full_cerr_before", 32'(credit_err), 32'd0);
        cyc(1'b1, 9'h0AA, 1'b0);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_cerr", 32'(credit_err), 32'd1);
        cyc(1'b1, 9'h1BB, 1'b1);
        check("fullrw_fill", 32'(fill_level), 32'd16);
        for (int i = 0; i < 16; i++) cyc(1'b0, 9'h0, 1'b1);
        check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
        check("drain_empty", 32'(rx_buf_empty), 32'd1);

        // Link drop with 5 stored and 11 outstanding, then reset mid-read
        do_reset();
        link_up = 1'b1;
        serve(40, n_req);
        for (int i = 0; i < 5; i++) cyc(1'b1, 9'(9'h60 + i), 1'b0);
        check("pre_drop_outstanding", 32'(dut.outstanding), 32'd11);
        link_up = 1'b0;
        tick();
        check("drop_outstanding", 32'(dut.outstanding), 32'd0);
        check("drop_req", 32'(credit_req), 32'd0);
        check("drop_fill", 32'(fill_level), 32'd5);
        cyc(1'b0, 9'h0, 1'b1);
        rx_buf_en = 1'b1;
        reset     = 1'b1;
        tick();
        rx_buf_en = 1'b0;
        reset     = 1'b0;
        check_reset_vals("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
